// File: rtl/player_pkg.sv
// Shared definitions for the player control slice: FSM state encoding and system clock rate.
package player_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam int CLK_HZ = 50_000_000;

endpackage : player_pkg

// File: rtl/play_ctrl_if.sv
// Key inputs, sequencer feedback and sequencer/buzzer control outputs of the player control stage.
interface play_ctrl_if;

    logic key_play;
    logic key_stop;
    logic song_end;
    logic mute;
    logic run;
    logic song_rst;
    logic paused;

    modport slave (
        input  key_play,
        input  key_stop,
        input  song_end,
        output mute,
        output run,
        output song_rst,
        output paused
    );

    modport master (
        output key_play,
        output key_stop,
        output song_end,
        input  mute,
        input  run,
        input  song_rst,
        input  paused
    );

endinterface : play_ctrl_if

// File: rtl/key_debounce.sv
// Synchroniser, stability counter and single-cycle press pulse for one active-low raw key.
module key_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT     = 1_000_000,
    parameter int CNT_W       = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   prev_q, prev_d;
    logic                   s;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], key_n};
        s        = sync_q[SYNC_STAGES-1];
        stable_d = stable_q;
        cnt_d    = cnt_q;
        prev_d   = stable_q;
        if (s == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEB_CNT - 1)) begin
            stable_d = s;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Press fires the cycle after the debounced level falls, so a held key gives one pulse.
    assign press = prev_q & ~stable_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '1;
            cnt_q    <= '0;
            stable_q <= 1'b1;
            prev_q   <= 1'b1;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
        end
    end

endmodule : key_debounce

// File: rtl/play_ctrl.sv
// Player control: debounced PLAY/PAUSE and STOP keys driving the IDLE/PLAY/PAUSE FSM.
// REPEAT_EN defined: song_end keeps playing; undefined: song_end ends play with a song_rst.
module play_ctrl
    import player_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT     = 1_000_000,
    parameter int CNT_W       = 20
) (
    input  logic        clk,
    input  logic        rst,
    play_ctrl_if.slave  bus
);

    logic   play_press;
    logic   stop_press;
    state_e state_q, state_d;
    logic   mute_q, mute_d;
    logic   run_q, run_d;
    logic   song_rst_q, song_rst_d;
    logic   paused_q, paused_d;

    key_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CNT    (DEB_CNT),
        .CNT_W      (CNT_W)
    ) u_deb_play (
        .clk  (clk),
        .rst  (rst),
        .key_n(bus.key_play),
        .press(play_press)
    );

    key_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CNT    (DEB_CNT),
        .CNT_W      (CNT_W)
    ) u_deb_stop (
        .clk  (clk),
        .rst  (rst),
        .key_n(bus.key_stop),
        .press(stop_press)
    );

    always_comb begin
        state_d    = state_q;
        song_rst_d = 1'b0;
        if (stop_press) begin
            // Stop overrides play and song_end, so only one restart pulse is ever issued.
            state_d    = IDLE;
            song_rst_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (play_press) begin
                        state_d    = PLAY;
                        song_rst_d = 1'b1;
                    end
                end
                PLAY: begin
                    if (play_press) begin
                        state_d = PAUSE;
`ifdef REPEAT_EN
                    end else if (bus.song_end) begin
                        state_d = PLAY;
`else
                    end else if (bus.song_end) begin
                        state_d    = IDLE;
                        song_rst_d = 1'b1;
`endif
                    end
                end
                PAUSE: begin
                    if (play_press) begin
                        state_d = PLAY;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        mute_d   = (state_d != PLAY);
        run_d    = (state_d == PLAY);
        paused_d = (state_d == PAUSE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mute_q     <= 1'b1;
            run_q      <= 1'b0;
            song_rst_q <= 1'b0;
            paused_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mute_q     <= mute_d;
            run_q      <= run_d;
            song_rst_q <= song_rst_d;
            paused_q   <= paused_d;
        end
    end

    assign bus.mute     = mute_q;
    assign bus.run      = run_q;
    assign bus.song_rst = song_rst_q;
    assign bus.paused   = paused_q;

endmodule : play_ctrl

// File: tb/tb_play_ctrl.sv
// Directed bench for play_ctrl with DEB_CNT=4, SYNC_STAGES=2; per-cycle output expectations in a scoreboard.
module tb_play_ctrl;

    // Output vectors ordered {mute, run, song_rst, paused}
    localparam logic [3:0] S_IDLE   = 4'b1000;
    localparam logic [3:0] S_IDLE_R = 4'b1010;
    localparam logic [3:0] S_PLAY   = 4'b0100;
    localparam logic [3:0] S_PLAY_R = 4'b0110;
    localparam logic [3:0] S_PAUSE  = 4'b1001;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [3:0] exp_q[$];
    string      tag_q[$];
    logic [3:0] exp_v;
    logic [3:0] obs_v;
    string      tag_v;
    logic [3:0] cur;

    play_ctrl_if bus ();

    play_ctrl #(
        .SYNC_STAGES(2),
        .DEB_CNT    (4),
        .CNT_W      (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            tag_v = tag_q.pop_front();
            obs_v = {bus.mute, bus.run, bus.song_rst, bus.paused};
            n_tests++;
            assert (obs_v === exp_v) else begin
                n_fail++;
                $error("FAIL %s: observed {mute,run,song_rst,paused}=%b expected %b", tag_v, obs_v, exp_v);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic chk_n(input int n, input logic [3:0] e, input string t);
        repeat (n) begin
            tick();
            push(e, t);
        end
    endtask

    // Play key pressed from a settled state: 6 edges unchanged, new state on edge 7, then held and released.
    task automatic press_play(input logic [3:0] from, input logic [3:0] first, input logic [3:0] to,
                              input string t);
        bus.key_play = 1'b0;
        chk_n(6, from, {t, "_pre"});
        chk_n(1, first, {t, "_edge7"});
        chk_n(9, to, {t, "_held"});
        bus.key_play = 1'b1;
        chk_n(10, to, {t, "_release"});
    endtask

    initial begin
        rst          = 1'b1;
        bus.key_play = 1'b1;
        bus.key_stop = 1'b1;
        bus.song_end = 1'b0;

        chk_n(2, S_IDLE, "reset");
        tick();
        rst = 1'b0;
        push(S_IDLE, "reset_release");

        // 1: idle after reset
        chk_n(100, S_IDLE, "idle_hold");

        // 2: long press from IDLE, one event only
        bus.key_play = 1'b0;
        chk_n(6, S_IDLE, "t2_pre");
        chk_n(1, S_PLAY_R, "t2_start");
        chk_n(13, S_PLAY, "t2_held");
        bus.key_play = 1'b1;
        chk_n(12, S_PLAY, "t2_release");

        // 3: glitch and bounce rejected
        bus.key_play = 1'b0;
        chk_n(3, S_PLAY, "t3_glitch");
        bus.key_play = 1'b1;
        chk_n(10, S_PLAY, "t3_glitch_after");
        for (int i = 0; i < 2; i++) begin
            bus.key_play = 1'b0;
            chk_n(2, S_PLAY, "t3_bounce_lo");
            bus.key_play = 1'b1;
            chk_n(2, S_PLAY, "t3_bounce_hi");
        end
        chk_n(10, S_PLAY, "t3_bounce_after");

        // 4: pause and resume without restart
        press_play(S_PLAY, S_PAUSE, S_PAUSE, "t4_pause");
        press_play(S_PAUSE, S_PLAY, S_PLAY, "t4_resume");

        // 5: simultaneous play+stop in PAUSE
        press_play(S_PLAY, S_PAUSE, S_PAUSE, "t5_pause");
        bus.key_play = 1'b0;
        bus.key_stop = 1'b0;
        chk_n(6, S_PAUSE, "t5_pre");
        chk_n(1, S_IDLE_R, "t5_stop_wins");
        chk_n(9, S_IDLE, "t5_held");
        bus.key_play = 1'b1;
        bus.key_stop = 1'b1;
        chk_n(10, S_IDLE, "t5_release");

        // 6: song_end in PLAY
        press_play(S_IDLE, S_PLAY_R, S_PLAY, "t6_play");
        bus.song_end = 1'b1;
`ifdef REPEAT_EN
        chk_n(1, S_PLAY, "t6_song_end_repeat");
        bus.song_end = 1'b0;
        chk_n(5, S_PLAY, "t6_after_repeat");
        cur = S_PLAY;
`else
        chk_n(1, S_IDLE_R, "t6_song_end_stop");
        bus.song_end = 1'b0;
        chk_n(5, S_IDLE, "t6_after_stop");
        cur = S_IDLE;
`endif

        // 6: reset while key_play held, then the held key is accepted again
        bus.key_play = 1'b0;
        chk_n(3, cur, "t6_hold_pre_rst");
        tick();
        rst = 1'b1;
        push(S_IDLE, "t6_rst_assert");
        chk_n(1, S_IDLE, "t6_rst_hold");
        tick();
        rst = 1'b0;
        push(S_IDLE, "t6_rst_release");
        chk_n(6, S_IDLE, "t6_redeb");
        chk_n(1, S_PLAY_R, "t6_replay");
        chk_n(5, S_PLAY, "t6_replay_held");
        bus.key_play = 1'b1;
        chk_n(10, S_PLAY, "t6_replay_release");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d pending entries, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_play_ctrl
